// File: rtl/pkt_deparse_emit.sv
// Packet deparser/emitter: buffers packet beats and per-packet metadata, then emits each
// packet through a single output register with optional MAC rewrite, or discards it.
module pkt_deparse_emit #(
    parameter int unsigned PKT_AW  = 6,
    parameter int unsigned META_AW = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_pkt_valid,
    input  logic [133:0] i_pkt,
    input  logic         i_meta_valid,
    input  logic [127:0] i_meta,
    input  logic         i_out_ready,
    output logic         o_data_valid,
    output logic [133:0] o_data,
    output logic         o_pkt_full,
    output logic         o_meta_full,
    output logic [15:0]  o_drop_cnt
);

    localparam int unsigned PKT_DEPTH  = 1 << PKT_AW;
    localparam int unsigned META_DEPTH = 1 << META_AW;
    localparam logic [PKT_AW:0]  PKT_FULL_CNT  = {1'b1, {PKT_AW{1'b0}}};
    localparam logic [META_AW:0] META_FULL_CNT = {1'b1, {META_AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_e;

    // Packet FIFO
    logic [133:0]      pkt_mem [PKT_DEPTH];
    logic [PKT_AW-1:0] pkt_wr_ptr_q, pkt_wr_ptr_d;
    logic [PKT_AW-1:0] pkt_rd_ptr_q, pkt_rd_ptr_d;
    logic [PKT_AW:0]   pkt_cnt_q, pkt_cnt_d;
    logic              pkt_full, pkt_empty, pkt_wr, pkt_rd, pkt_ovf;
    logic [133:0]      pkt_head;

    // Metadata FIFO
    logic [127:0]       meta_mem [META_DEPTH];
    logic [META_AW-1:0] meta_wr_ptr_q, meta_wr_ptr_d;
    logic [META_AW-1:0] meta_rd_ptr_q, meta_rd_ptr_d;
    logic [META_AW:0]   meta_cnt_q, meta_cnt_d;
    logic               meta_full, meta_empty, meta_wr, meta_rd, meta_ovf;
    logic [127:0]       meta_head;

    // Emit path
    state_e       state_q, state_d;
    logic         drop_q, drop_d;
    logic         rw_q, rw_d;
    logic [47:0]  dst_q, dst_d;
    logic [47:0]  src_q, src_d;
    logic         out_valid_q, out_valid_d;
    logic [133:0] out_data_q, out_data_d;
    logic         out_free, load;
    logic [133:0] load_data;
    logic [15:0]  drop_cnt_q, drop_cnt_d;
    logic [16:0]  drop_sum;

    assign pkt_full   = (pkt_cnt_q == PKT_FULL_CNT);
    assign pkt_empty  = (pkt_cnt_q == '0);
    assign meta_full  = (meta_cnt_q == META_FULL_CNT);
    assign meta_empty = (meta_cnt_q == '0);

    // A full FIFO refuses writes even if it is being read in the same cycle.
    assign pkt_wr   = i_pkt_valid && !pkt_full;
    assign pkt_ovf  = i_pkt_valid && pkt_full;
    assign meta_wr  = i_meta_valid && !meta_full;
    assign meta_ovf = i_meta_valid && meta_full;

    assign pkt_head  = pkt_mem[pkt_rd_ptr_q];
    assign meta_head = meta_mem[meta_rd_ptr_q];

    always_ff @(posedge i_clk) begin
        if (pkt_wr) begin
            pkt_mem[pkt_wr_ptr_q] <= i_pkt;
        end
        if (meta_wr) begin
            meta_mem[meta_wr_ptr_q] <= i_meta;
        end
    end

    always_comb begin
        pkt_wr_ptr_d  = pkt_wr ? pkt_wr_ptr_q + PKT_AW'(1) : pkt_wr_ptr_q;
        pkt_rd_ptr_d  = pkt_rd ? pkt_rd_ptr_q + PKT_AW'(1) : pkt_rd_ptr_q;
        pkt_cnt_d     = pkt_cnt_q + (PKT_AW + 1)'(pkt_wr) - (PKT_AW + 1)'(pkt_rd);
        meta_wr_ptr_d = meta_wr ? meta_wr_ptr_q + META_AW'(1) : meta_wr_ptr_q;
        meta_rd_ptr_d = meta_rd ? meta_rd_ptr_q + META_AW'(1) : meta_rd_ptr_q;
        meta_cnt_d    = meta_cnt_q + (META_AW + 1)'(meta_wr) - (META_AW + 1)'(meta_rd);
    end

    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q} + 17'(pkt_ovf) + 17'(meta_ovf);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    assign out_free = !out_valid_q || i_out_ready;

    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        rw_d      = rw_q;
        dst_d     = dst_q;
        src_d     = src_q;
        meta_rd   = 1'b0;
        pkt_rd    = 1'b0;
        load      = 1'b0;
        load_data = pkt_head;

        unique case (state_q)
            IDLE: begin
                if (!pkt_empty && !meta_empty && out_free) begin
                    meta_rd = 1'b1;
                    drop_d  = meta_head[127];
                    rw_d    = meta_head[126];
                    dst_d   = meta_head[95:48];
                    src_d   = meta_head[47:0];
                    state_d = HEAD;
                end
            end
            HEAD, BODY: begin
                // Dropped packets drain without waiting on the output register.
                if (!pkt_empty && (drop_q || out_free)) begin
                    pkt_rd = 1'b1;
                    load   = !drop_q;
                    if (state_q == HEAD && rw_q) begin
                        load_data[127:80] = dst_q;
                        load_data[79:32]  = src_q;
                    end
                    state_d = pkt_head[133] ? IDLE : BODY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_data_d = load ? load_data : out_data_q;
        if (load) begin
            out_valid_d = 1'b1;
        end else if (i_out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pkt_wr_ptr_q  <= '0;
            pkt_rd_ptr_q  <= '0;
            pkt_cnt_q     <= '0;
            meta_wr_ptr_q <= '0;
            meta_rd_ptr_q <= '0;
            meta_cnt_q    <= '0;
            state_q       <= IDLE;
            drop_q        <= 1'b0;
            rw_q          <= 1'b0;
            dst_q         <= '0;
            src_q         <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pkt_wr_ptr_q  <= pkt_wr_ptr_d;
            pkt_rd_ptr_q  <= pkt_rd_ptr_d;
            pkt_cnt_q     <= pkt_cnt_d;
            meta_wr_ptr_q <= meta_wr_ptr_d;
            meta_rd_ptr_q <= meta_rd_ptr_d;
            meta_cnt_q    <= meta_cnt_d;
            state_q       <= state_d;
            drop_q        <= drop_d;
            rw_q          <= rw_d;
            dst_q         <= dst_d;
            src_q         <= src_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign o_data_valid = out_valid_q;
    assign o_data       = out_data_q;
    assign o_pkt_full   = pkt_full;
    assign o_meta_full  = meta_full;
    assign o_drop_cnt   = drop_cnt_q;

endmodule
